// File: rtl/uart8_rx_oversampled_pkg.sv
// Shared definitions for the Uart8 receive path: FSM state encoding and divider/vote helpers.
package uart8_rx_oversampled_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START_BIT = 2'd1,
        DATA_BITS = 2'd2,
        STOP_BIT  = 2'd3
    } rx_state_t;

    // Integer-truncated clocks per oversample tick, never below 1.
    function automatic int calc_div(input int clock_rate, input int baud_rate, input int oversample);
        int d;
        d = clock_rate / (baud_rate * oversample);
        return (d < 1) ? 1 : d;
    endfunction

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart8_rx_oversampled_tick.sv
// Oversample tick divider: registered one-clk pulse every DIV clocks while enabled.
// Dropping the enable clears the phase so the next tick is a full DIV clocks later.
module uart8_rx_oversampled_tick #(
    parameter int DIV = 78
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (!en) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt == CW'(DIV - 1)) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + 1'b1;
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/uart8_rx_oversampled.sv
// 8N1 UART receiver: 2-flop synchronizer, 3-sample majority vote per bit, framing-error detection.
// rxDone fires ~9.6 bit times after the start edge; there is no backpressure, the consumer must take rxOut on rxDone.
module uart8_rx_oversampled
    import uart8_rx_oversampled_pkg::*;
#(
    parameter int CLOCK_RATE   = 12000000,
    parameter int BAUD_RATE    = 9600,
    parameter int OVERSAMPLE   = 16,
    parameter int TURBO_FRAMES = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxEn,
    input  logic       rxIn,
    output logic       rxBusy,
    output logic       rxDone,
    output logic       rxErr,
    output logic [7:0] rxOut
);

    localparam int DIV   = calc_div(CLOCK_RATE, BAUD_RATE, OVERSAMPLE);
    localparam int SW    = $clog2(OVERSAMPLE);
    localparam logic [SW-1:0] S_LO  = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_MID = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] S_HI  = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [SW-1:0] S_END = SW'(OVERSAMPLE - 1);

    logic [1:0]    sync;
    logic          rx_s;
    logic          tick;
    logic          vote;
    rx_state_t     state;
    logic          armed;
    logic [SW-1:0] s_idx;
    logic [2:0]    bit_idx;
    logic          v0;
    logic          v1;
    logic [7:0]    shreg;

    uart8_rx_oversampled_tick #(
        .DIV (DIV)
    ) u_tick (
        .clk   (clk),
        .rst_n (reset),
        .en    (rxEn),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], rxIn};
        end
    end

    assign rx_s = sync[1];
    // Third vote sample is the live one; the first two were captured on earlier ticks.
    assign vote = majority3(v0, v1, rx_s);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            armed   <= 1'b0;
            s_idx   <= '0;
            bit_idx <= '0;
            v0      <= 1'b0;
            v1      <= 1'b0;
            shreg   <= '0;
            rxBusy  <= 1'b0;
            rxDone  <= 1'b0;
            rxErr   <= 1'b0;
            rxOut   <= '0;
        end else begin
            rxDone <= 1'b0;
            if (!rxEn) begin
                state   <= IDLE;
                armed   <= 1'b0;
                rxBusy  <= 1'b0;
                s_idx   <= '0;
                bit_idx <= '0;
            end else if (tick) begin
                if (s_idx == S_LO)  v0 <= rx_s;
                if (s_idx == S_MID) v1 <= rx_s;
                unique case (state)
                    IDLE: begin
                        s_idx <= '0;
                        if (!rx_s && armed) begin
                            // The detecting tick is sample 0 of the start bit.
                            state  <= START_BIT;
                            s_idx  <= SW'(1);
                            rxBusy <= 1'b1;
                            rxErr  <= 1'b0;
                        end else if (rx_s) begin
                            armed <= 1'b1;
                        end
                    end
                    START_BIT: begin
                        if (s_idx == S_HI && vote) begin
                            state  <= IDLE;
                            rxBusy <= 1'b0;
                            armed  <= 1'b1;
                            s_idx  <= '0;
                        end else if (s_idx == S_END) begin
                            state   <= DATA_BITS;
                            s_idx   <= '0;
                            bit_idx <= '0;
                        end else begin
                            s_idx <= s_idx + 1'b1;
                        end
                    end
                    DATA_BITS: begin
                        if (s_idx == S_HI) shreg <= {vote, shreg[7:1]};
                        if (s_idx == S_END) begin
                            s_idx <= '0;
                            if (bit_idx == 3'd7) state <= STOP_BIT;
                            else                 bit_idx <= bit_idx + 1'b1;
                        end else begin
                            s_idx <= s_idx + 1'b1;
                        end
                    end
                    STOP_BIT: begin
                        if (s_idx == S_HI) begin
                            if (vote) begin
                                rxOut  <= shreg;
                                rxDone <= 1'b1;
                                if (TURBO_FRAMES != 0) begin
                                    state  <= IDLE;
                                    rxBusy <= 1'b0;
                                    armed  <= 1'b1;
                                    s_idx  <= '0;
                                end else begin
                                    s_idx <= s_idx + 1'b1;
                                end
                            end else begin
                                // Disarm so a held-low line (break) cannot start a new frame.
                                rxErr  <= 1'b1;
                                state  <= IDLE;
                                rxBusy <= 1'b0;
                                armed  <= 1'b0;
                                s_idx  <= '0;
                            end
                        end else if (s_idx == S_END) begin
                            state  <= IDLE;
                            rxBusy <= 1'b0;
                            armed  <= 1'b1;
                            s_idx  <= '0;
                        end else begin
                            s_idx <= s_idx + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart8_rx_oversampled.sv
// Directed bench: table of 8N1 frames on a normal receiver, plus glitch, enable-abort, reset and turbo sequences.
module tb_uart8_rx_oversampled;

    localparam int CR   = 2000000;
    localparam int BR   = 9600;
    localparam int OS   = 16;
    localparam int DIV  = CR / (BR * OS);
    localparam int BIT  = DIV * OS;
    localparam int LAT  = (9 * OS + OS / 2 + 1) * DIV;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx_en = 1'b1;
    logic       rx_a = 1'b1;
    logic       rx_b = 1'b1;
    logic       busy_a, done_a, err_a;
    logic       busy_b, done_b, err_b;
    logic [7:0] out_a, out_b;

    always #5 clk = ~clk;

    uart8_rx_oversampled #(
        .CLOCK_RATE(CR), .BAUD_RATE(BR), .OVERSAMPLE(OS), .TURBO_FRAMES(0)
    ) dut_a (
        .clk(clk), .reset(reset), .rxEn(rx_en), .rxIn(rx_a),
        .rxBusy(busy_a), .rxDone(done_a), .rxErr(err_a), .rxOut(out_a)
    );

    uart8_rx_oversampled #(
        .CLOCK_RATE(CR), .BAUD_RATE(BR), .OVERSAMPLE(OS), .TURBO_FRAMES(1)
    ) dut_b (
        .clk(clk), .reset(reset), .rxEn(rx_en), .rxIn(rx_b),
        .rxBusy(busy_b), .rxDone(done_b), .rxErr(err_b), .rxOut(out_b)
    );

    int         n_cmp = 0;
    int         n_bad = 0;
    longint     cyc = 0;
    int         done_cnt_a = 0;
    int         done_cnt_b = 0;
    int         dbl_done = 0;
    longint     last_done_cyc_a = 0;
    logic       prev_done_a = 1'b0;
    logic       prev_done_b = 1'b0;
    int         busy_run_a = 0;
    int         busy_max_a = 0;
    logic [7:0] hist_b[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done_a) begin
            done_cnt_a++;
            last_done_cyc_a = cyc;
            if (prev_done_a) dbl_done++;
        end
        if (done_b) begin
            done_cnt_b++;
            hist_b.push_back(out_b);
            if (prev_done_b) dbl_done++;
        end
        prev_done_a = done_a;
        prev_done_b = done_b;
        if (busy_a) begin
            busy_run_a++;
            if (busy_run_a > busy_max_a) busy_max_a = busy_run_a;
        end else begin
            busy_run_a = 0;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input longint act, input longint lo, input longint hi);
        n_cmp++;
        if (act < lo || act > hi) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after nbits bit times.
    task automatic drive(input bit sel, input logic v, input int nbits);
        if (sel) rx_b = v;
        else     rx_a = v;
        repeat (nbits * BIT) @(posedge clk);
        #1;
    endtask

    task automatic send(input bit sel, input logic [7:0] d, input logic stop,
                        output logic mid_busy, output logic mid_err, output longint t0);
        t0 = cyc;
        mid_busy = 1'b0;
        mid_err  = 1'b1;
        drive(sel, 1'b0, 1);
        for (int i = 0; i < 8; i++) begin
            drive(sel, d[i], 1);
            if (i == 0) begin
                mid_busy = sel ? busy_b : busy_a;
                mid_err  = sel ? err_b : err_a;
            end
        end
        drive(sel, stop, 1);
        if (sel) rx_b = 1'b1;
        else     rx_a = 1'b1;
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         exp_done;
        logic [7:0] exp_out;
        logic       exp_err;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic       mb, me;
        longint     t0;
        int         d0;
        logic [7:0] frame;

        vecs[0] = '{8'h7A, 1'b1, 1, 8'h7A, 1'b0};
        vecs[1] = '{8'h55, 1'b0, 0, 8'h7A, 1'b1};
        vecs[2] = '{8'hA5, 1'b1, 1, 8'hA5, 1'b0};
        vecs[3] = '{8'h00, 1'b1, 1, 8'h00, 1'b0};
        vecs[4] = '{8'hFF, 1'b1, 1, 8'hFF, 1'b0};

        repeat (5) @(posedge clk);
        #1;
        check("reset_busy", busy_a, 1'b0);
        check("reset_done", done_a, 1'b0);
        check("reset_err",  err_a,  1'b0);
        check("reset_out",  out_a,  8'h00);
        reset = 1'b1;
        repeat (2 * BIT) @(posedge clk);
        #1;

        for (int i = 0; i < 5; i++) begin
            d0 = done_cnt_a;
            send(1'b0, vecs[i].data, vecs[i].stop, mb, me, t0);
            drive(1'b0, 1'b1, 1);
            check($sformatf("v%0d_done", i), done_cnt_a - d0, vecs[i].exp_done);
            check($sformatf("v%0d_out", i),  out_a,  vecs[i].exp_out);
            check($sformatf("v%0d_err", i),  err_a,  vecs[i].exp_err);
            check($sformatf("v%0d_idle", i), busy_a, 1'b0);
            check($sformatf("v%0d_midbusy", i), mb, 1'b1);
            check($sformatf("v%0d_miderr", i),  me, 1'b0);
            if (i == 0) check_range("latency", last_done_cyc_a - t0, LAT, LAT + 2 * DIV);
        end

        // Short low glitch on an idle line
        d0 = done_cnt_a;
        busy_max_a = 0;
        rx_a = 1'b0;
        repeat (3 * DIV) @(posedge clk);
        #1;
        drive(1'b0, 1'b1, 2);
        check_range("glitch_busy_len", busy_max_a, 1, BIT - 1);
        check("glitch_done", done_cnt_a - d0, 0);
        check("glitch_err",  err_a, 1'b0);
        check("glitch_out",  out_a, 8'hFF);

        // Receiver disabled during data bit 3 of 0x3C
        frame = 8'h3C;
        d0 = done_cnt_a;
        drive(1'b0, 1'b0, 1);
        for (int i = 0; i < 3; i++) drive(1'b0, frame[i], 1);
        rx_a = frame[3];
        repeat (BIT / 2) @(posedge clk);
        #1;
        check("abort_busy_before", busy_a, 1'b1);
        rx_en = 1'b0;
        @(posedge clk);
        #1;
        check("abort_busy_after", busy_a, 1'b0);
        drive(1'b0, 1'b1, 8);
        check("abort_done", done_cnt_a - d0, 0);
        check("abort_out",  out_a, 8'hFF);
        check("abort_err",  err_a, 1'b0);
        rx_en = 1'b1;
        drive(1'b0, 1'b1, 1);
        send(1'b0, frame, 1'b1, mb, me, t0);
        drive(1'b0, 1'b1, 1);
        check("resend_done", done_cnt_a - d0, 1);
        check("resend_out",  out_a, 8'h3C);

        // Back-to-back frames on the turbo receiver
        send(1'b1, 8'h7A, 1'b1, mb, me, t0);
        send(1'b1, 8'hB1, 1'b1, mb, me, t0);
        drive(1'b1, 1'b1, 1);
        check("turbo_done_cnt", done_cnt_b, 2);
        check("turbo_first",  (hist_b.size() > 0) ? hist_b[0] : 8'hxx, 8'h7A);
        check("turbo_second", (hist_b.size() > 1) ? hist_b[1] : 8'hxx, 8'hB1);
        check("turbo_err",  err_b, 1'b0);
        check("turbo_busy", busy_b, 1'b0);

        // Reset mid-frame with the line held low
        frame = 8'h81;
        drive(1'b0, 1'b0, 1);
        drive(1'b0, frame[0], 1);
        rx_a = 1'b0;
        repeat (BIT / 2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("rst_busy", busy_a, 1'b0);
        check("rst_out",  out_a,  8'h00);
        check("rst_err",  err_a,  1'b0);
        check("rst_done", done_a, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        busy_max_a = 0;
        d0 = done_cnt_a;
        drive(1'b0, 1'b0, 3);
        check("rst_low_nostart", busy_max_a, 0);
        drive(1'b0, 1'b1, 1);
        send(1'b0, frame, 1'b1, mb, me, t0);
        drive(1'b0, 1'b1, 1);
        check("post_rst_done", done_cnt_a - d0, 1);
        check("post_rst_out",  out_a, 8'h81);

        check("no_double_done", dbl_done, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
